stat_stack_ctrl: RTL and testbench
==================================

Name: stat_stack_ctrl

Overview:
- Multi-lane status controller for the vector unit; successor to the single-lane status register.
- Generates per-lane {Eq,Ne,Gt,Le} from adder difference values, in integer or float mode.
- Holds a DEPTH-entry stack of lane masks for nested conditional execution (push / pop / else).
- Drives the lane-enable mask consumed by the vector lanes.

Parameters:
NUM_LANE, 8, number of vector lanes
WIDTH_DATA, 32, width of one lane difference value
DEPTH, 4, mask-stack entries (>=1)
WIDTH_DEPTH, $clog2(DEPTH+1), width of stack-depth count

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
I_Req  in  1  status update request
I_Mode  in  1  0 = signed integer, 1 = float
I_Diff_Data  in  NUM_LANE*WIDTH_DATA  per-lane difference; lane i is [i*WIDTH_DATA +: WIDTH_DATA]
I_Cond  in  2  status bit that forms the mask: 0 Eq, 1 Ne, 2 Gt, 3 Le
I_Push  in  1  push mask (if)
I_Pop  in  1  pop mask (endif); I_Push&I_Pop = else
I_Clr  in  1  clear sticky error
O_Status  out  NUM_LANE*4  per-lane {Eq,Ne,Gt,Le}, lane i at [i*4 +: 4]
O_Mask  out  NUM_LANE  active lane mask
O_Depth  out  WIDTH_DEPTH  stack entries in use
O_Full  out  1  O_Depth==DEPTH
O_Empty  out  1  O_Depth==0
O_Err  out  1  sticky overflow/underflow/else-on-empty

Behaviour:
- Reset values: O_Status=0, O_Mask=all ones, O_Depth=0, O_Empty=1, O_Full=0, O_Err=0, stack contents=0.
- Per-lane flags, let s = MSB of the lane:
  - Integer mode: Eq = (all bits ==0).
  - Float mode: Eq = (bits [WIDTH_DATA-2:0] ==0), so -0 counts as equal.
  - Both modes: Ne=~Eq; Gt = s & Ne; Le = ~s | Eq.
- Status register:
  - On I_Req, lanes with O_Mask[i]=1 load their new flags; masked-off lanes hold.
  - Latency 1 cycle.
- Let C = per-lane bit selected by I_Cond from the *registered* O_Status, i.e. the value before any same-cycle I_Req update.
- Push only, not full: stack[O_Depth] <= O_Mask; O_Mask <= O_Mask & C; O_Depth+1.
- Pop only, not empty: O_Mask <= stack[O_Depth-1]; O_Depth-1.
- Push&Pop (else), not empty: O_Mask <= stack[O_Depth-1] & ~C; depth and stack unchanged.
- Push when full, or pop/else when empty: no change to mask, stack or depth; O_Err<=1.
- O_Err stays set until I_Clr or reset. If I_Clr coincides with a new error, the error wins.
- I_Req and stack operations in the same cycle are independent: the stack uses the old status, and the status update uses the old mask.
- O_Full and O_Empty are decoded from registered O_Depth.
- Reset mid-sequence discards the whole stack; there is no drain.

Optional Feature:
- Macro: STAT_STACK_CTRL_UNORD_EN.
- When defined:
  - Adds output O_Unord (NUM_LANE).
  - In float mode, a lane whose difference is NaN (exponent all ones, mantissa !=0) loads status 4'b0000 and sets O_Unord[i]. The register updates on the same I_Req and with the same lane masking as O_Status.
  - O_Unord resets to 0.
- When undefined: no port; NaN bit patterns are classified like any other value.

Decomposition:
- Shared package: stat_v_t (4-bit {Eq,Ne,Gt,Le}), cond-select encodings, NUM_LANE and WIDTH_DATA defaults, status bit-index constants.
- Sub-module stat_lane: one lane's flag decode plus its 4-bit status register with enable.
- The stack, mask and error logic stay in the top level.

Test Plan:
- Reset, then I_Req with lane0 diff 0, lane1 0xFFFFFFFF, lane2 0x00000005, int mode -> next cycle lane0 {1,0,0,1}, lane1 {0,1,1,0}, lane2 {0,1,0,1}.
- Float mode, diff 0x80000000 -> {1,0,0,1}; same value in int mode -> {0,1,1,0}.
- Status lanes 0-3 Gt, I_Cond=2, I_Push -> O_Mask=0x0F, depth 1. Then I_Push&I_Pop -> O_Mask=0xF0. Then I_Pop -> O_Mask=0xFF, O_Empty=1.
- DEPTH=4, five pushes -> depth stays 4, O_Full=1, O_Err=1, mask unchanged by 5th push. I_Clr -> O_Err=0.
- O_Mask=0x0F, I_Req with all diffs 0 -> only lanes 0-3 change; lanes 4-7 hold prior status. Pop at depth 0 -> O_Err=1.
- With UNORD_EN, float diff 0x7FC00000 -> status 0000, O_Unord[i]=1. Without the macro -> {0,1,0,1}.

Source files
------------

// File: rtl/stat_stack_ctrl_pkg.sv
// stat_stack_ctrl_pkg: shared types and constants for the multi-lane status/mask-stack controller
package stat_stack_ctrl_pkg;
  typedef logic [3:0] stat_v_t;
  localparam int NUM_LANE_DEF = 8;
  localparam int WIDTH_DATA_DEF = 32;
  localparam int EXP_W = 8;
  localparam int IDX_EQ = 3;
  localparam int IDX_NE = 2;
  localparam int IDX_GT = 1;
  localparam int IDX_LE = 0;
  localparam logic [1:0] COND_EQ = 2'd0;
  localparam logic [1:0] COND_NE = 2'd1;
  localparam logic [1:0] COND_GT = 2'd2;
  localparam logic [1:0] COND_LE = 2'd3;
  function automatic logic [1:0] cond_idx(input logic [1:0] cond);
    return 2'd3 - cond;
  endfunction
endpackage

// File: rtl/stat_stack_ctrl_if.sv
// stat_stack_ctrl_if: request/stack-control inputs and status/mask outputs; O_Unord under STAT_STACK_CTRL_UNORD_EN
interface stat_stack_ctrl_if #(
  parameter int NUM_LANE = 8,
  parameter int WIDTH_DATA = 32,
  parameter int WIDTH_DEPTH = 3
);
  logic                           I_Req;
  logic                           I_Mode;
  logic [NUM_LANE*WIDTH_DATA-1:0] I_Diff_Data;
  logic [1:0]                     I_Cond;
  logic                           I_Push;
  logic                           I_Pop;
  logic                           I_Clr;
  logic [NUM_LANE*4-1:0]          O_Status;
  logic [NUM_LANE-1:0]            O_Mask;
  logic [WIDTH_DEPTH-1:0]         O_Depth;
  logic                           O_Full;
  logic                           O_Empty;
  logic                           O_Err;
`ifdef STAT_STACK_CTRL_UNORD_EN
  logic [NUM_LANE-1:0]            O_Unord;
  modport master (output I_Req, I_Mode, I_Diff_Data, I_Cond, I_Push, I_Pop, I_Clr,
                  input O_Status, O_Mask, O_Depth, O_Full, O_Empty, O_Err, O_Unord);
  modport slave (input I_Req, I_Mode, I_Diff_Data, I_Cond, I_Push, I_Pop, I_Clr,
                 output O_Status, O_Mask, O_Depth, O_Full, O_Empty, O_Err, O_Unord);
`else
  modport master (output I_Req, I_Mode, I_Diff_Data, I_Cond, I_Push, I_Pop, I_Clr,
                  input O_Status, O_Mask, O_Depth, O_Full, O_Empty, O_Err);
  modport slave (input I_Req, I_Mode, I_Diff_Data, I_Cond, I_Push, I_Pop, I_Clr,
                 output O_Status, O_Mask, O_Depth, O_Full, O_Empty, O_Err);
`endif
endinterface

// File: rtl/stat_stack_ctrl_lane.sv
// stat_lane: one lane's {Eq,Ne,Gt,Le} decode and enabled status register; NaN handling under STAT_STACK_CTRL_UNORD_EN
module stat_lane
  import stat_stack_ctrl_pkg::*;
#(
  parameter int WIDTH_DATA = WIDTH_DATA_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  mode,
  input  logic [WIDTH_DATA-1:0] diff,
`ifdef STAT_STACK_CTRL_UNORD_EN
  output logic                  unord,
`endif
  output stat_v_t               status
);
  logic s, eq;
  stat_v_t flags;
  always_comb begin
    s = diff[WIDTH_DATA-1];
    eq = mode ? ~|diff[WIDTH_DATA-2:0] : ~|diff;
    flags = '0;
    flags[IDX_EQ] = eq;
    flags[IDX_NE] = ~eq;
    flags[IDX_GT] = s & ~eq;
    flags[IDX_LE] = ~s | eq;
  end
`ifdef STAT_STACK_CTRL_UNORD_EN
  logic nan;
  assign nan = mode & (&diff[WIDTH_DATA-2 -: EXP_W]) & (|diff[WIDTH_DATA-2-EXP_W:0]);
  always_ff @(posedge clock)
    if (reset) begin
      status <= '0;
      unord <= 1'b0;
    end else if (en) begin
      status <= nan ? '0 : flags;
      unord <= nan;
    end
`else
  always_ff @(posedge clock)
    if (reset) status <= '0;
    else if (en) status <= flags;
`endif
endmodule

// File: rtl/stat_stack_ctrl.sv
// stat_stack_ctrl: per-lane status registers plus nested-conditional lane-mask stack; optional NaN output via STAT_STACK_CTRL_UNORD_EN
module stat_stack_ctrl
  import stat_stack_ctrl_pkg::*;
#(
  parameter int NUM_LANE = NUM_LANE_DEF,
  parameter int WIDTH_DATA = WIDTH_DATA_DEF,
  parameter int DEPTH = 4,
  parameter int WIDTH_DEPTH = $clog2(DEPTH+1)
) (
  input logic clock,
  input logic reset,
  stat_stack_ctrl_if.slave bus
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [NUM_LANE*4-1:0]  status;
  logic [NUM_LANE-1:0]    mask, c;
  logic [NUM_LANE-1:0]    stack [DEPTH];
  logic [WIDTH_DEPTH-1:0] depth;
  logic                   err, full, empty, push_op, pop_op, else_op, err_ev;
  logic [IW-1:0]          wr_idx, rd_idx;
  logic [1:0]             cidx;
  for (genvar i = 0; i < NUM_LANE; i++) begin : g_lane
    stat_lane #(.WIDTH_DATA(WIDTH_DATA)) u_lane (
      .clock(clock),
      .reset(reset),
      .en(bus.I_Req & mask[i]),
      .mode(bus.I_Mode),
      .diff(bus.I_Diff_Data[i*WIDTH_DATA +: WIDTH_DATA]),
`ifdef STAT_STACK_CTRL_UNORD_EN
      .unord(bus.O_Unord[i]),
`endif
      .status(status[i*4 +: 4])
    );
  end
  always_comb begin
    cidx = cond_idx(bus.I_Cond);
    c = '0;
    for (int i = 0; i < NUM_LANE; i++) c[i] = status[i*4 + int'(cidx)];
    full = depth == WIDTH_DEPTH'(DEPTH);
    empty = depth == '0;
    push_op = bus.I_Push & ~bus.I_Pop;
    pop_op = bus.I_Pop & ~bus.I_Push;
    else_op = bus.I_Push & bus.I_Pop;
    err_ev = (push_op & full) | ((pop_op | else_op) & empty);
    wr_idx = IW'(depth);
    rd_idx = IW'(depth - 1'b1);
  end
  always_ff @(posedge clock)
    if (reset) begin
      mask <= '1;
      depth <= '0;
      err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stack[i] <= '0;
    end else begin
      err <= err_ev | (err & ~bus.I_Clr);
      if (push_op && !full) begin
        stack[wr_idx] <= mask;
        mask <= mask & c;
        depth <= depth + 1'b1;
      end else if (pop_op && !empty) begin
        mask <= stack[rd_idx];
        depth <= depth - 1'b1;
      end else if (else_op && !empty) begin
        mask <= stack[rd_idx] & ~c;
      end
    end
  assign bus.O_Status = status;
  assign bus.O_Mask = mask;
  assign bus.O_Depth = depth;
  assign bus.O_Full = full;
  assign bus.O_Empty = empty;
  assign bus.O_Err = err;
endmodule

// File: tb/tb_stat_stack_ctrl.sv
// tb_stat_stack_ctrl: directed self-checking bench for stat_stack_ctrl
module tb_stat_stack_ctrl;
  localparam int NL = 8;
  localparam int WD = 32;
  localparam int WDP = 3;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clock = ~clock;
  stat_stack_ctrl_if #(.NUM_LANE(NL), .WIDTH_DATA(WD), .WIDTH_DEPTH(WDP)) bus ();
  stat_stack_ctrl #(.NUM_LANE(NL), .WIDTH_DATA(WD), .DEPTH(4), .WIDTH_DEPTH(WDP)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.slave)
  );
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
    bus.I_Req = 1'b0;
    bus.I_Push = 1'b0;
    bus.I_Pop = 1'b0;
    bus.I_Clr = 1'b0;
  endtask
  task automatic req(input logic mode, input logic [NL*WD-1:0] d);
    bus.I_Req = 1'b1;
    bus.I_Mode = mode;
    bus.I_Diff_Data = d;
  endtask
  task automatic stk(input logic push, input logic pop, input logic [1:0] cond);
    bus.I_Push = push;
    bus.I_Pop = pop;
    bus.I_Cond = cond;
  endtask
  function automatic logic [NL*WD-1:0] fill(input logic [WD-1:0] lo, input logic [WD-1:0] hi, input int split);
    logic [NL*WD-1:0] d;
    for (int i = 0; i < NL; i++) d[i*WD +: WD] = i < split ? lo : hi;
    return d;
  endfunction
  initial begin
    logic [NL*WD-1:0] d;
    bus.I_Req = 0; bus.I_Mode = 0; bus.I_Diff_Data = '0; bus.I_Cond = 0;
    bus.I_Push = 0; bus.I_Pop = 0; bus.I_Clr = 0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    chk("rst_status", bus.O_Status, 0);
    chk("rst_mask", bus.O_Mask, 8'hFF);
    chk("rst_depth", bus.O_Depth, 0);
    chk("rst_empty", bus.O_Empty, 1);
    chk("rst_full", bus.O_Full, 0);
    chk("rst_err", bus.O_Err, 0);
    d = fill(32'h1, 32'h1, 0);
    d[0 +: WD] = 32'h0; d[WD +: WD] = 32'hFFFF_FFFF; d[2*WD +: WD] = 32'h5;
    req(0, d); step();
    chk("int_status", bus.O_Status, 32'h5555_5569);
    d[0 +: WD] = 32'h8000_0000;
    req(1, d); step();
    chk("flt_negzero", bus.O_Status[3:0], 4'h9);
    req(0, d); step();
    chk("int_negzero", bus.O_Status[3:0], 4'h6);
    req(0, fill(32'hFFFF_FFFF, 32'h1, 4)); step();
    chk("gt_status", bus.O_Status, 32'h5555_6666);
    stk(1, 0, 2); step();
    chk("push_mask", bus.O_Mask, 8'h0F);
    chk("push_depth", bus.O_Depth, 1);
    stk(1, 1, 2); step();
    chk("else_mask", bus.O_Mask, 8'hF0);
    chk("else_depth", bus.O_Depth, 1);
    stk(0, 1, 2); step();
    chk("pop_mask", bus.O_Mask, 8'hFF);
    chk("pop_empty", bus.O_Empty, 1);
    for (int i = 0; i < 4; i++) begin stk(1, 0, 2); step(); end
    chk("full4_depth", bus.O_Depth, 4);
    chk("full4_full", bus.O_Full, 1);
    chk("full4_err", bus.O_Err, 0);
    stk(1, 0, 3); step();
    chk("ovf_depth", bus.O_Depth, 4);
    chk("ovf_mask", bus.O_Mask, 8'h0F);
    chk("ovf_err", bus.O_Err, 1);
    bus.I_Clr = 1; step();
    chk("clr_err", bus.O_Err, 0);
    stk(1, 0, 2); bus.I_Clr = 1; step();
    chk("clr_vs_err", bus.O_Err, 1);
    bus.I_Clr = 1; step();
    req(0, '0); step();
    chk("masked_req", bus.O_Status, 32'h5555_9999);
    for (int i = 0; i < 3; i++) begin stk(0, 1, 0); step(); end
    chk("pop3_mask", bus.O_Mask, 8'h0F);
    stk(0, 1, 0); step();
    chk("pop4_mask", bus.O_Mask, 8'hFF);
    chk("pop4_depth", bus.O_Depth, 0);
    stk(0, 1, 0); step();
    chk("unf_err", bus.O_Err, 1);
    chk("unf_depth", bus.O_Depth, 0);
    chk("unf_mask", bus.O_Mask, 8'hFF);
    bus.I_Clr = 1; step();
    stk(1, 1, 0); step();
    chk("else_empty_err", bus.O_Err, 1);
    chk("else_empty_mask", bus.O_Mask, 8'hFF);
    bus.I_Clr = 1; step();
    req(0, fill(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0)); stk(1, 0, 0); step();
    chk("indep_mask", bus.O_Mask, 8'h0F);
    chk("indep_status", bus.O_Status, 32'h6666_6666);
    stk(0, 1, 0); step();
    d = fill(32'h1, 32'h1, 0);
    d[0 +: WD] = 32'h7FC0_0000;
    req(1, d); step();
`ifdef STAT_STACK_CTRL_UNORD_EN
    chk("nan_status", bus.O_Status, 32'h5555_5550);
    chk("nan_unord", bus.O_Unord, 8'h01);
`else
    chk("nan_status", bus.O_Status, 32'h5555_5555);
`endif
    stk(1, 0, 1); step();
    chk("pre_rst_depth", bus.O_Depth, 1);
    reset = 1'b1; step(); reset = 1'b0;
    chk("mid_rst_depth", bus.O_Depth, 0);
    chk("mid_rst_mask", bus.O_Mask, 8'hFF);
    chk("mid_rst_status", bus.O_Status, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
